mod_unit_32bit: RTL and testbench



---
 rtl/alu_pkg.sv | 10 +
 rtl/mod_unit_32bit_if.sv | 12 +
 rtl/mod_step_32bit.sv | 12 +
 rtl/sub_32bit.sv | 9 +
 rtl/mod_unit_32bit.sv | 65 ++++++
 tb/tb_mod_unit_32bit.sv | 125 ++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, modulo-unit FSM encodings and ALU control codes
package alu_pkg;
  localparam int MOD_WIDTH = 32;
  localparam logic [2:0] ALU_MOD = 3'b111;
  typedef enum logic [1:0] {
    MOD_IDLE = 2'b00,
    MOD_RUN  = 2'b01,
    MOD_DONE = 2'b10
  } mod_state_t;
endpackage

// File: rtl/mod_unit_32bit_if.sv
// mod_unit_32bit_if: request/result bundle between control and the modulo unit
interface mod_unit_32bit_if import alu_pkg::*; #(parameter int WIDTH = MOD_WIDTH);
  logic             start;
  logic [WIDTH-1:0] mod_src1;
  logic [WIDTH-1:0] mod_src2;
  logic [WIDTH-1:0] mod_result;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master (output start, mod_src1, mod_src2, input mod_result, busy, done, div_zero);
  modport slave  (input start, mod_src1, mod_src2, output mod_result, busy, done, div_zero);
endinterface

// File: rtl/mod_step_32bit.sv
// mod_step_32bit: one restoring compare-and-subtract step of the remainder
module mod_step_32bit import alu_pkg::*; (
  input  logic [MOD_WIDTH:0]   t_i,
  input  logic [MOD_WIDTH-1:0] divisor_i,
  output logic [MOD_WIDTH:0]   rem_o
);
  logic [MOD_WIDTH-1:0] diff;
  logic                 borrow;
  sub_32bit u_sub (.a_i(t_i[MOD_WIDTH-1:0]), .b_i(divisor_i), .diff_o(diff), .borrow_o(borrow));
  // t < 2*divisor always, so a set top bit means t >= divisor and the low-bit difference is exact
  assign rem_o = (t_i[MOD_WIDTH] | ~borrow) ? {1'b0, diff} : t_i;
endmodule

// File: rtl/sub_32bit.sv
// sub_32bit: unsigned 32-bit subtractor with borrow out
module sub_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        borrow_o
);
  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
endmodule

// File: rtl/mod_unit_32bit.sv
// mod_unit_32bit: multi-cycle unsigned remainder (mod_src1 mod mod_src2) feeding the ALU mux
module mod_unit_32bit import alu_pkg::*; #(parameter int WIDTH = MOD_WIDTH) (
  input logic             CLK,
  input logic             reset,
  mod_unit_32bit_if.slave m
);
  localparam int CW = $clog2(WIDTH);
  mod_state_t       state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d, result_q, result_d;
  logic [WIDTH:0]   rem_q, rem_d, rem_nx;
  logic [CW-1:0]    count_q, count_d;
  logic             dz_q, dz_d;
  mod_step_32bit u_step (.t_i({rem_q[WIDTH-1:0], dividend_q[WIDTH-1]}), .divisor_i(divisor_q), .rem_o(rem_nx));
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    count_d    = count_q;
    result_d   = result_q;
    dz_d       = dz_q;
    case (state_q)
      MOD_IDLE: if (m.start) begin
        dividend_d = m.mod_src1;
        divisor_d  = m.mod_src2;
        rem_d      = '0;
        count_d    = '0;
        dz_d       = (m.mod_src2 == '0);
        result_d   = dz_d ? m.mod_src1 : result_q;
        state_d    = dz_d ? MOD_DONE : MOD_RUN;
      end
      MOD_RUN: begin
        dividend_d = dividend_q << 1;
        rem_d      = rem_nx;
        count_d    = count_q + 1'b1;
        result_d   = (count_q == CW'(WIDTH - 1)) ? rem_nx[WIDTH-1:0] : result_q;
        state_d    = (count_q == CW'(WIDTH - 1)) ? MOD_DONE : MOD_RUN;
      end
      default: state_d = MOD_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= MOD_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      result_q   <= result_d;
      dz_q       <= dz_d;
    end
  end
  assign m.mod_result = result_q;
  assign m.div_zero   = dz_q;
  assign m.busy       = (state_q == MOD_RUN);
  assign m.done       = (state_q == MOD_DONE);
endmodule

// File: tb/tb_mod_unit_32bit.sv
// tb_mod_unit_32bit: scoreboard bench for the multi-cycle modulo unit
module tb_mod_unit_32bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_cnt = 0;
  logic [32:0] sb_q[$];
  mod_unit_32bit_if dut_if ();
  mod_unit_32bit dut (.CLK(clk), .reset(rst), .m(dut_if.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    logic [32:0] e;
    if (dut_if.done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        chk("result", {32'd0, dut_if.mod_result}, {32'd0, e[32:1]});
        chk("div_zero", {63'd0, dut_if.div_zero}, {63'd0, e[0]});
      end
    end
  end
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? {a, 1'b1} : {a % b, 1'b0};
  endfunction
  task automatic wait_done();
    int n = 0;
    while (dut_if.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("done_timeout", 64'd1, 64'd0);
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int lat = 1;
    int bz = 0;
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.mod_src1 = a;
    dut_if.mod_src2 = b;
    sb_q.push_back(model(a, b));
    @(negedge clk);
    dut_if.start = 1'b0;
    dut_if.mod_src1 = $urandom;
    dut_if.mod_src2 = $urandom;
    while (dut_if.done !== 1'b1 && lat < 40) begin
      bz += int'(dut_if.busy);
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), (b == 0) ? 64'd1 : 64'd33);
    chk("busy_cycles", 64'(bz), (b == 0) ? 64'd0 : 64'd32);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, dut_if.done}, 64'd0);
  endtask
  logic [31:0] op_a[9] = '{32'd100, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'd5, 32'd1234, 32'hDEADBEEF, 32'hFFFFFFFF, 32'd0};
  logic [31:0] op_b[9] = '{32'd7, 32'h10, 32'hFFFFFFFF, 32'd9, 32'd0, 32'd1234, 32'd1, 32'hFFFFFFFF, 32'd3};
  initial begin
    int d0;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    dut_if.start = 1'b0;
    dut_if.mod_src1 = '0;
    dut_if.mod_src2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, dut_if.busy}, 64'd0);
    chk("rst_done", {63'd0, dut_if.done}, 64'd0);
    chk("rst_result", {32'd0, dut_if.mod_result}, 64'd0);
    chk("rst_div_zero", {63'd0, dut_if.div_zero}, 64'd0);
    for (int i = 0; i < 9; i++) run_op(op_a[i], op_b[i]);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom_range(1, 1000));
    d0 = done_cnt;
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.mod_src1 = 32'd100;
    dut_if.mod_src2 = 32'd7;
    sb_q.push_back(model(32'd100, 32'd7));
    @(negedge clk);
    dut_if.start = 1'b0;
    repeat (4) @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.mod_src1 = 32'd55;
    dut_if.mod_src2 = 32'd3;
    @(negedge clk);
    dut_if.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("ignored_start_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("ignored_start_idle", {63'd0, dut_if.busy}, 64'd0);
    d0 = done_cnt;
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.mod_src1 = 32'd100;
    dut_if.mod_src2 = 32'd7;
    @(negedge clk);
    dut_if.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, dut_if.busy}, 64'd0);
    chk("abort_done", {63'd0, dut_if.done}, 64'd0);
    chk("abort_result", {32'd0, dut_if.mod_result}, 64'd0);
    chk("abort_div_zero", {63'd0, dut_if.div_zero}, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_op(32'd1000, 32'd13);
    chk("result_held_idle", {32'd0, dut_if.mod_result}, 64'd12);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
